sram_extension_param: RTL and testbench
=======================================

SRAM_EXTENSION_PARAM -- requirements
Module: sram_extension_param

Interface
REQ-001 Parameter BW_DATA, default 256, total data word width in bits.
REQ-002 Parameter BW_ADDR, default 10, total address width; depth is 2**BW_ADDR words.
REQ-003 Parameter BW_DATA_UNIT, default 64, data width of one unit SRAM.
REQ-004 Parameter BW_ADDR_UNIT, default 6, address width of one unit SRAM; unit depth is 2**BW_ADDR_UNIT.
REQ-005 Port i_clk, input, 1, single clock; all state on its rising edge.
REQ-006 Port i_rstn, input, 1, reset: one clock; asynchronous, active-low.
REQ-007 Port i_data, input, BW_DATA, write data.
REQ-008 Port i_addr, input, BW_ADDR, word address.
REQ-009 Port i_wen, input, 1, write enable, active-high.
REQ-010 Port i_oen, input, 1, read (output) enable, active-high.
REQ-011 Port o_data, output, BW_DATA, registered read data.

Function
REQ-012 Array SHALL be NCOL = BW_DATA/BW_DATA_UNIT unit SRAMs wide by NROW = 2**(BW_ADDR-BW_ADDR_UNIT) unit SRAMs deep; defaults give 4 x 16 = 64 units.
REQ-013 Legal parameters SHALL satisfy BW_DATA a multiple of BW_DATA_UNIT and BW_ADDR >= BW_ADDR_UNIT; elaboration SHALL fail otherwise.
REQ-014 Row select SHALL be i_addr[BW_ADDR-1:BW_ADDR_UNIT], decoded one-hot into chip enable cen[NROW-1:0]; unit address SHALL be i_addr[BW_ADDR_UNIT-1:0].
REQ-015 Column c of every row SHALL store i_data[c*BW_DATA_UNIT +: BW_DATA_UNIT].
REQ-016 Write: i_wen=1 at rising edge SHALL store i_data into all NCOL units of the selected row at the unit address; other rows unchanged.
REQ-017 Read: i_oen=1 and i_wen=0 at rising edge SHALL present the stored word at o_data after that edge (1-cycle latency).
REQ-018 Output mux SHALL use the row select registered in the read cycle, so o_data is stable for the full following cycle.
REQ-019 i_wen=1 and i_oen=1 together: write SHALL be performed, no read; o_data SHALL hold.
REQ-020 i_wen=0 and i_oen=0 (standby): no unit is enabled, memory unchanged, o_data SHALL hold its last value.
REQ-021 Read of a never-written location SHALL return unknown/unspecified data; the bench SHALL not check it.
REQ-022 Read-after-write to the same address in consecutive cycles SHALL return the newly written data.
REQ-023 Address space SHALL not wrap or alias: all 2**BW_ADDR addresses are distinct.

Reset
REQ-024 i_rstn=0 SHALL asynchronously clear o_data to 0 and the registered row select to 0.
REQ-025 Reset SHALL not clear memory contents; data written before reset SHALL remain readable after release.
REQ-026 Reset asserted during a write cycle: write SHALL be suppressed; no unit is enabled while i_rstn=0.
REQ-027 Operation SHALL resume on the first rising edge after i_rstn deasserts.

Structure
REQ-028 Shared package SHALL hold nothing block-specific; NCOL/NROW SHALL be local parameters derived from module parameters.
REQ-029 One sub-module SHALL be used: spsram, single-port synchronous SRAM (BW_DATA_UNIT x 2**BW_ADDR_UNIT, ports o_data, i_data, i_addr, i_cen, i_wen, i_oen, i_clk), instantiated NROW x NCOL in generate loops.
REQ-030 Top level SHALL contain only the decoder, generate array, row-select register and output mux/register.

Verification
REQ-031 Reset: drive i_rstn=0 then release -> o_data = 0.
REQ-032 Full fill: write data=i (zero-extended to 256 bits) at addr i for i=0..1023, then read i=0..1023 -> o_data = i one cycle after each read.
REQ-033 Bank boundary: write 0xAAAA at addr 63, 0x5555 at addr 64; read 63 then 64 -> 0xAAAA then 0x5555; other rows unchanged.
REQ-034 Column split: write {64'h4,64'h3,64'h2,64'h1} at addr 5, read addr 5 -> same 256-bit word, each 64-bit slice correct.
REQ-035 Simultaneous i_wen=1,i_oen=1 at addr 7 with data 0x77 -> o_data holds previous value; subsequent read of 7 -> 0x77.
REQ-036 Reset mid-operation: write 0x99 at addr 10, assert i_rstn=0 -> o_data=0 immediately; release, read addr 10 -> 0x99.

Source files
------------

// File: rtl/sram_extension_param_pkg.sv
// Generic memory-access helpers shared across the core.
// Holds only block-independent types.
package sram_extension_param_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } sram_op_e;

endpackage

// File: rtl/sram_extension_param_spsram.sv
// Single-port synchronous SRAM unit.
// Read data is registered and holds unless a read is performed.
module spsram #(
  parameter int BW_DATA = 64,
  parameter int BW_ADDR = 6
) (
  output logic [BW_DATA-1:0] o_data,
  input  logic [BW_DATA-1:0] i_data,
  input  logic [BW_ADDR-1:0] i_addr,
  input  logic               i_cen,
  input  logic               i_wen,
  input  logic               i_oen,
  input  logic               i_clk
);

  logic [BW_DATA-1:0] mem_q [2**BW_ADDR];
  logic [BW_DATA-1:0] rdata_q;

  // Macro-style array: no reset on contents or read latch.
  always_ff @(posedge i_clk) begin
    if (i_cen) begin
      if (i_wen) begin
        mem_q[i_addr] <= i_data;
      end else if (i_oen) begin
        rdata_q <= mem_q[i_addr];
      end
    end
  end

  assign o_data = rdata_q;

endmodule

// File: rtl/sram_extension_param.sv
// Wide/deep SRAM built from an NROW x NCOL array of spsram units.
// Row-select decoder, unit array, row register and output mux.
module sram_extension_param
  import sram_extension_param_pkg::*;
#(
  parameter int BW_DATA      = 256,
  parameter int BW_ADDR      = 10,
  parameter int BW_DATA_UNIT = 64,
  parameter int BW_ADDR_UNIT = 6
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [BW_DATA-1:0] i_data,
  input  logic [BW_ADDR-1:0] i_addr,
  input  logic               i_wen,
  input  logic               i_oen,
  output logic [BW_DATA-1:0] o_data
);

  localparam int NCOL   = BW_DATA / BW_DATA_UNIT;
  localparam int NROW   = 2**(BW_ADDR - BW_ADDR_UNIT);
  localparam int BW_ROW =
    (BW_ADDR > BW_ADDR_UNIT) ? BW_ADDR - BW_ADDR_UNIT : 1;

  if ((BW_DATA % BW_DATA_UNIT) != 0 ||
      BW_ADDR < BW_ADDR_UNIT) begin : g_bad_param
    $error("sram_extension_param: illegal geometry");
  end

  logic [BW_ROW-1:0]       row;
  logic [BW_ADDR_UNIT-1:0] uaddr;
  logic [NROW-1:0]         cen;
  logic [BW_DATA-1:0]      row_rd [NROW];
  sram_op_e                op;
  logic [BW_ROW-1:0]       row_d, row_q;
  logic                    vld_d, vld_q;

  if (NROW > 1) begin : g_row
    assign row = i_addr[BW_ADDR-1:BW_ADDR_UNIT];
  end else begin : g_row1
    assign row = '0;
  end

  assign uaddr = i_addr[BW_ADDR_UNIT-1:0];

  // Reset masks every access so a write cannot land mid-reset.
  always_comb begin
    op = OP_IDLE;
    unique case (1'b1)
      !i_rstn:                      op = OP_IDLE;
      i_rstn && i_wen:              op = OP_WRITE;
      i_rstn && !i_wen && i_oen:    op = OP_READ;
      i_rstn && !i_wen && !i_oen:   op = OP_IDLE;
      default:                      op = OP_IDLE;
    endcase
  end

  for (genvar r = 0; r < NROW; r++) begin : g_r
    assign cen[r] = (op != OP_IDLE) && (row == BW_ROW'(r));
    for (genvar c = 0; c < NCOL; c++) begin : g_c
      spsram #(
        .BW_DATA(BW_DATA_UNIT),
        .BW_ADDR(BW_ADDR_UNIT)
      ) u_unit (
        .o_data(row_rd[r][c*BW_DATA_UNIT +: BW_DATA_UNIT]),
        .i_data(i_data[c*BW_DATA_UNIT +: BW_DATA_UNIT]),
        .i_addr(uaddr),
        .i_cen (cen[r]),
        .i_wen (op == OP_WRITE),
        .i_oen (op == OP_READ),
        .i_clk (i_clk)
      );
    end
  end

  always_comb begin
    row_d = row_q;
    vld_d = vld_q;
    if (op == OP_READ) begin
      row_d = row;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      row_q <= '0;
      vld_q <= 1'b0;
    end else begin
      row_q <= row_d;
      vld_q <= vld_d;
    end
  end

  // vld_q forces zero until the first read after reset.
  assign o_data = vld_q ? row_rd[row_q] : '0;

endmodule

// File: tb/tb_sram_extension_param.sv
// Directed bench for sram_extension_param with default geometry.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_sram_extension_param;

  logic         i_clk;
  logic         i_rstn;
  logic [255:0] i_data;
  logic [9:0]   i_addr;
  logic         i_wen;
  logic         i_oen;
  logic [255:0] o_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic         wen;
    logic         oen;
    logic [9:0]   addr;
    logic [255:0] data;
    logic         chk;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs[$];

  sram_extension_param dut (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_data(i_data),
    .i_addr(i_addr),
    .i_wen (i_wen),
    .i_oen (i_oen),
    .o_data(o_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name,
                       input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, then advance to the next falling edge.
  task automatic cyc(input logic w, input logic o,
                     input logic [9:0] a,
                     input logic [255:0] d);
    i_wen  = w;
    i_oen  = o;
    i_addr = a;
    i_data = d;
    @(negedge i_clk);
  endtask

  localparam logic [255:0] COLW =
    {64'h4, 64'h3, 64'h2, 64'h1};

  initial begin
    logic [255:0] w;
    i_rstn = 1'b1;
    i_wen  = 1'b0;
    i_oen  = 1'b0;
    i_addr = '0;
    i_data = '0;

    #3 i_rstn = 1'b0;
    #1 check("reset_low", o_data, 256'h0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    cyc(1'b0, 1'b0, 10'd0, '0);
    check("reset_release", o_data, 256'h0);

    for (int i = 0; i < 1024; i++)
      cyc(1'b1, 1'b0, 10'(i), 256'(i));
    check("fill_write_hold", o_data, 256'h0);
    for (int i = 0; i < 1024; i++) begin
      cyc(1'b0, 1'b1, 10'(i), '0);
      check($sformatf("fill_rd_%0d", i), o_data, 256'(i));
    end

    vecs.push_back('{"bnd_w63", 1, 0, 10'd63,  256'hAAAA, 0, 256'h0});
    vecs.push_back('{"bnd_w64", 1, 0, 10'd64,  256'h5555, 0, 256'h0});
    vecs.push_back('{"bnd_r63", 0, 1, 10'd63,  256'h0, 1, 256'hAAAA});
    vecs.push_back('{"bnd_r64", 0, 1, 10'd64,  256'h0, 1, 256'h5555});
    vecs.push_back('{"standby", 0, 0, 10'd3,   256'h0, 1, 256'h5555});
    vecs.push_back('{"bnd_r62", 0, 1, 10'd62,  256'h0, 1, 256'd62});
    vecs.push_back('{"bnd_r65", 0, 1, 10'd65,  256'h0, 1, 256'd65});
    vecs.push_back('{"bnd_r127", 0, 1, 10'd127, 256'h0, 1, 256'd127});
    vecs.push_back('{"col_w5", 1, 0, 10'd5, COLW, 1, 256'd127});
    vecs.push_back('{"col_r5", 0, 1, 10'd5, 256'h0, 1, COLW});
    vecs.push_back('{"r6", 0, 1, 10'd6, 256'h0, 1, 256'd6});
    vecs.push_back('{"wo_7", 1, 1, 10'd7, 256'h77, 1, 256'd6});
    vecs.push_back('{"wo_r7", 0, 1, 10'd7, 256'h0, 1, 256'h77});
    vecs.push_back('{"raw_w", 1, 0, 10'd1023, 256'hDEAD, 1, 256'h77});
    vecs.push_back('{"raw_r", 0, 1, 10'd1023, 256'h0, 1, 256'hDEAD});
    vecs.push_back('{"alias_0", 0, 1, 10'd0, 256'h0, 1, 256'h0});
    vecs.push_back('{"alias_512", 0, 1, 10'd512, 256'h0, 1, 256'd512});
    vecs.push_back('{"alias_960", 0, 1, 10'd960, 256'h0, 1, 256'd960});

    foreach (vecs[k]) begin
      cyc(vecs[k].wen, vecs[k].oen, vecs[k].addr, vecs[k].data);
      if (vecs[k].chk)
        check(vecs[k].name, o_data, vecs[k].exp);
    end

    cyc(1'b0, 1'b1, 10'd5, '0);
    w = o_data;
    for (int s = 0; s < 4; s++)
      check($sformatf("col_slice_%0d", s),
            {192'h0, w[s*64 +: 64]}, 256'(s + 1));

    cyc(1'b0, 1'b1, 10'd3, '0);
    check("pre_rst_r3", o_data, 256'd3);
    cyc(1'b1, 1'b0, 10'd10, 256'h99);
    i_wen  = 1'b1;
    i_oen  = 1'b0;
    i_addr = 10'd11;
    i_data = 256'hBB;
    #2 i_rstn = 1'b0;
    #1 check("rst_async", o_data, 256'h0);
    @(negedge i_clk);
    check("rst_hold", o_data, 256'h0);
    i_rstn = 1'b1;
    cyc(1'b0, 1'b0, 10'd0, '0);
    check("rst_standby", o_data, 256'h0);
    cyc(1'b0, 1'b1, 10'd10, '0);
    check("rst_keep_10", o_data, 256'h99);
    cyc(1'b0, 1'b1, 10'd11, '0);
    check("rst_nowr_11", o_data, 256'd11);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
